// File: rtl/colour_scan_controller.sv
// Colour-sensor scan sequencer: steps through the red/green/blue/clear filters,
// averages the sensor output period for each and classifies the dominant colour.
module colour_scan_controller #(
  parameter int SETTLE_CYCLES = 1000,
  parameter int AVG_LOG2      = 2,
  parameter int WHITE_MIN     = 80,
  parameter int WHITE_MAX     = 250
) (
  input  logic        scaled_clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        continuous,
  input  logic        cs_output,
  output logic        cs_S0,
  output logic        cs_S1,
  output logic        cs_S2,
  output logic        cs_S3,
  output logic        cs_en,
  output logic [15:0] red,
  output logic [15:0] green,
  output logic [15:0] blue,
  output logic [15:0] white,
  output logic [1:0]  cd_out,
  output logic        result_valid,
  output logic        busy,
  output logic        timeout_err
);

  localparam int AW = 16 + AVG_LOG2;
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int NW = AVG_LOG2 + 1;
  localparam logic [NW-1:0] LAST_PER = NW'((1 << AVG_LOG2) - 1);
  localparam logic [15:0]   SAT      = 16'hFFFF;

  typedef enum logic [2:0] {IDLE, SETTLE, SYNC, MEASURE, NEXT, DECIDE} state_t;

  state_t          state;
  logic [2:0]      sync_q;
  logic [SW-1:0]   settle_cnt;
  logic [15:0]     cnt;
  logic [15:0]     period;
  logic [AW-1:0]   acc;
  logic [AW-1:0]   acc_sum;
  logic [NW-1:0]   nper;
  logic [1:0]      filt;
  logic            rise;
  logic            sat;
  logic            begin_scan;

  // Filter index order is red, green, blue, clear.
  function automatic logic [1:0] filt_code(input logic [1:0] f);
    case (f)
      2'd0:    return 2'b00;
      2'd1:    return 2'b11;
      2'd2:    return 2'b01;
      default: return 2'b10;
    endcase
  endfunction

  function automatic logic [1:0] decide(input logic [15:0] r, g, b, w);
    if (w < 16'(WHITE_MIN) || w > 16'(WHITE_MAX)) return 2'b11;
    if (r < g && r < b) return 2'b00;
    if (g < r && g < b) return 2'b01;
    if (b < r && b < g) return 2'b10;
    return 2'b11;
  endfunction

  assign cs_S0      = 1'b1;
  assign cs_S1      = 1'b0;
  assign rise       = sync_q[1] & ~sync_q[2];
  assign sat        = (cnt == SAT);
  assign period     = sat ? SAT : cnt + 16'd1;
  assign acc_sum    = acc + AW'(period);
  assign begin_scan = ((state == IDLE) && (start || continuous)) ||
                      ((state == DECIDE) && continuous);

  always_ff @(posedge scaled_clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      sync_q       <= '0;
      settle_cnt   <= '0;
      cnt          <= '0;
      acc          <= '0;
      nper         <= '0;
      filt         <= '0;
      cs_S2        <= 1'b0;
      cs_S3        <= 1'b0;
      cs_en        <= 1'b1;
      red          <= '0;
      green        <= '0;
      blue         <= '0;
      white        <= '0;
      cd_out       <= 2'b11;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      sync_q       <= {sync_q[1:0], cs_output};
      result_valid <= 1'b0;
      case (state)
        SETTLE: begin
          if (settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
            settle_cnt <= '0;
            cnt        <= '0;
            state      <= SYNC;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        SYNC: begin
          acc  <= '0;
          nper <= '0;
          if (rise) begin
            cnt   <= '0;
            state <= MEASURE;
          end else if (sat) begin
            // cnt stays saturated so MEASURE books SAT for every period
            timeout_err <= 1'b1;
            state       <= MEASURE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        MEASURE: begin
          if (sat || rise) begin
            if (sat) timeout_err <= 1'b1;
            else     cnt <= '0;
            if (nper == LAST_PER) begin
              case (filt)
                2'd0:    red   <= acc_sum[AVG_LOG2 +: 16];
                2'd1:    green <= acc_sum[AVG_LOG2 +: 16];
                2'd2:    blue  <= acc_sum[AVG_LOG2 +: 16];
                default: white <= acc_sum[AVG_LOG2 +: 16];
              endcase
              state <= NEXT;
            end else begin
              acc  <= acc_sum;
              nper <= nper + 1'b1;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        NEXT: begin
          if (filt == 2'd3) begin
            cd_out       <= decide(red, green, blue, white);
            result_valid <= 1'b1;
            state        <= DECIDE;
          end else begin
            filt           <= filt + 2'd1;
            {cs_S2, cs_S3} <= filt_code(filt + 2'd1);
            state          <= SETTLE;
          end
        end
        DECIDE: begin
          state <= IDLE;
          busy  <= 1'b0;
          cs_en <= 1'b1;
        end
        default: state <= IDLE;
      endcase
      // Shared scan entry from IDLE and from DECIDE in continuous mode
      if (begin_scan) begin
        state          <= SETTLE;
        filt           <= 2'd0;
        {cs_S2, cs_S3} <= 2'b00;
        cs_en          <= 1'b0;
        busy           <= 1'b1;
        timeout_err    <= 1'b0;
        settle_cnt     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_colour_scan_controller.sv
// Bench for colour_scan_controller: a behavioural sensor driven by the filter
// selects, with expected scan results queued at start and matched on result_valid.
module tb_colour_scan_controller;

  typedef struct packed {
    logic [15:0] r, g, b, w;
    logic [1:0]  cd;
    logic        te;
  } res_t;

  localparam logic [73:0] RST_VEC = {5'b10001, 64'd0, 2'b11, 3'b000};

  logic        scaled_clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        continuous = 1'b0;
  logic        cs_output = 1'b0;
  logic        cs_S0, cs_S1, cs_S2, cs_S3, cs_en;
  logic [15:0] red, green, blue, white;
  logic [1:0]  cd_out;
  logic        result_valid, busy, timeout_err;

  int   total = 0;
  int   bad = 0;
  res_t exp_q[$];
  res_t obs_q[$];
  logic [1:0] seq_q[$];
  logic [1:0] s_prev = 2'b00;
  int   rv_cnt = 0;

  int   per_tab[4];
  bit   red_var = 1'b0;
  int   var_seq[4] = '{100, 102, 98, 104};
  int   dec_tab[4][5] = '{'{90, 90, 150, 120, 3}, '{50, 70, 90, 60, 3},
                          '{60, 30, 50, 80, 1},   '{60, 50, 30, 250, 2}};
  logic [2:0] last_sel = 3'b100;
  bit   dead = 1'b1;
  int   ph = 0, kper = 0, cur_p = 0;

  colour_scan_controller #(
    .SETTLE_CYCLES(8), .AVG_LOG2(2), .WHITE_MIN(80), .WHITE_MAX(250)
  ) dut (
    .scaled_clock(scaled_clock), .reset_n(reset_n), .start(start),
    .continuous(continuous), .cs_output(cs_output),
    .cs_S0(cs_S0), .cs_S1(cs_S1), .cs_S2(cs_S2), .cs_S3(cs_S3), .cs_en(cs_en),
    .red(red), .green(green), .blue(blue), .white(white), .cd_out(cd_out),
    .result_valid(result_valid), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 scaled_clock = ~scaled_clock;

  function automatic int fidx(input logic [1:0] s);
    case (s)
      2'b00:   return 0;
      2'b11:   return 1;
      2'b01:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic int sens_period(input int f, input int n);
    if (f == 0 && red_var) return var_seq[n % 4];
    return per_tab[f];
  endfunction

  function automatic res_t mk(input int r, g, b, w, input logic [1:0] cd, input logic te);
    return {16'(r), 16'(g), 16'(b), 16'(w), cd, te};
  endfunction

  function automatic string fmt(input res_t x);
    return $sformatf("r=%0d g=%0d b=%0d w=%0d cd=%b te=%b", x.r, x.g, x.b, x.w, x.cd, x.te);
  endfunction

  function automatic logic [73:0] out_vec();
    return {cs_S0, cs_S1, cs_S2, cs_S3, cs_en, red, green, blue, white,
            cd_out, result_valid, busy, timeout_err};
  endfunction

  // Sensor: restarts on any filter/enable change, idles 20 cycles, then emits
  // rising edges exactly one period apart (period 0 = output held low).
  always @(negedge scaled_clock) begin : sensor_model
    logic [2:0] sel;
    sel = {cs_en, cs_S2, cs_S3};
    if (sel !== last_sel) begin
      last_sel = sel; dead = 1'b1; ph = 0; kper = 0; cs_output = 1'b0;
    end else if (dead) begin
      ph++;
      if (ph >= 20 && sens_period(fidx(sel[1:0]), 0) != 0) begin
        dead = 1'b0; ph = 0; cur_p = sens_period(fidx(sel[1:0]), 0); cs_output = 1'b1;
      end
    end else begin
      ph++;
      if (ph == cur_p / 2) cs_output = 1'b0;
      if (ph == cur_p) begin
        kper++; ph = 0; cur_p = sens_period(fidx(sel[1:0]), kper); cs_output = 1'b1;
      end
    end
  end

  always @(negedge scaled_clock) begin : monitor
    if (result_valid === 1'b1) begin
      rv_cnt++;
      obs_q.push_back({red, green, blue, white, cd_out, timeout_err});
    end
    if ({cs_S2, cs_S3} !== s_prev) begin
      seq_q.push_back({cs_S2, cs_S3});
      s_prev = {cs_S2, cs_S3};
    end
  end

  task automatic set_periods(input int r, g, b, w);
    per_tab[0] = r; per_tab[1] = g; per_tab[2] = b; per_tab[3] = w;
  endtask

  task automatic pulse_start;
    @(negedge scaled_clock); start = 1'b1;
    @(negedge scaled_clock); start = 1'b0;
  endtask

  task automatic wait_obs(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (obs_q.size() > 0) ok = 1'b1;
      else @(negedge scaled_clock);
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge scaled_clock); n++;
    end
    if (busy !== 1'b0) begin
      total++; bad++;
      $display("FAIL idle_wait: busy=%b after %0d cycles, required 0", busy, budget);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(negedge scaled_clock);
    total++;
    if (out_vec() !== RST_VEC) begin
      bad++; $display("FAIL reset_values: got %h required %h", out_vec(), RST_VEC);
    end
    reset_n = 1'b1;
    repeat (20) @(negedge scaled_clock);
    total++;
    if (busy !== 1'b0 || cs_en !== 1'b1) begin
      bad++; $display("FAIL reset_idle: busy=%b cs_en=%b required 0/1", busy, cs_en);
    end
  endtask

  task automatic test_basic;
    bit seen;
    res_t got, want;
    exp_q.delete(); obs_q.delete();
    set_periods(100, 200, 300, 150);
    exp_q.push_back(mk(100, 200, 300, 150, 2'b00, 1'b0));
    pulse_start;
    total++;
    if (busy !== 1'b1 || cs_en !== 1'b0 || {cs_S2, cs_S3} !== 2'b00) begin
      bad++; $display("FAIL scan_start: busy=%b cs_en=%b s23=%b required 1/0/00",
                      busy, cs_en, {cs_S2, cs_S3});
    end
    seen = 1'b0;
    for (int i = 0; i < 20000 && !seen; i++) begin
      @(negedge scaled_clock);
      if (result_valid === 1'b1) seen = 1'b1;
    end
    total++;
    if (!seen || busy !== 1'b1) begin
      bad++; $display("FAIL rv_pulse: seen=%b busy=%b required 1/1", seen, busy);
    end
    @(negedge scaled_clock);
    total++;
    if (result_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL busy_fall: rv=%b busy=%b required 0/0", result_valid, busy);
    end
    total++;
    if (obs_q.size() == 0) begin
      bad++; $display("FAIL basic_scan: no result captured");
    end else begin
      got = obs_q.pop_front(); want = exp_q.pop_front();
      if (got !== want) begin
        bad++; $display("FAIL basic_scan: got %s required %s", fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_decisions;
    bit ok;
    res_t got, want;
    for (int i = 0; i < 4; i++) begin
      exp_q.delete(); obs_q.delete();
      set_periods(dec_tab[i][0], dec_tab[i][1], dec_tab[i][2], dec_tab[i][3]);
      exp_q.push_back(mk(dec_tab[i][0], dec_tab[i][1], dec_tab[i][2], dec_tab[i][3],
                         2'(dec_tab[i][4]), 1'b0));
      pulse_start;
      wait_obs(20000, ok);
      total++;
      if (!ok) begin
        bad++; $display("FAIL decide_%0d: no result_valid within 20000 cycles", i);
      end else begin
        got = obs_q.pop_front(); want = exp_q.pop_front();
        if (got !== want) begin
          bad++; $display("FAIL decide_%0d: got %s required %s", i, fmt(got), fmt(want));
        end
      end
      wait_idle(100);
    end
  endtask

  task automatic test_average;
    bit ok;
    res_t got, want;
    exp_q.delete(); obs_q.delete();
    red_var = 1'b1;
    set_periods(0, 120, 130, 140);
    exp_q.push_back(mk(101, 120, 130, 140, 2'b00, 1'b0));
    pulse_start;
    wait_obs(20000, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL average: no result_valid within 20000 cycles");
    end else begin
      got = obs_q.pop_front(); want = exp_q.pop_front();
      if (got !== want) begin
        bad++; $display("FAIL average: got %s required %s", fmt(got), fmt(want));
      end
    end
    red_var = 1'b0;
    wait_idle(100);
  endtask

  task automatic test_start_ignored;
    bit ok;
    int n0;
    res_t got, want;
    exp_q.delete(); obs_q.delete();
    set_periods(40, 50, 60, 100);
    exp_q.push_back(mk(40, 50, 60, 100, 2'b00, 1'b0));
    n0 = rv_cnt;
    pulse_start;
    repeat (60) @(negedge scaled_clock);
    pulse_start;
    wait_obs(20000, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL start_busy: no result_valid within 20000 cycles");
    end else begin
      got = obs_q.pop_front(); want = exp_q.pop_front();
      if (got !== want) begin
        bad++; $display("FAIL start_busy: got %s required %s", fmt(got), fmt(want));
      end
    end
    wait_idle(100);
    repeat (100) @(negedge scaled_clock);
    total++;
    if (rv_cnt - n0 !== 1 || busy !== 1'b0) begin
      bad++; $display("FAIL start_busy_count: pulses=%0d busy=%b required 1/0", rv_cnt - n0, busy);
    end
  endtask

  task automatic test_continuous;
    bit ok;
    int n0, n;
    logic [15:0] seq_got;
    res_t got, want;
    exp_q.delete(); obs_q.delete(); seq_q.delete();
    set_periods(30, 40, 50, 100);
    exp_q.push_back(mk(30, 40, 50, 100, 2'b00, 1'b0));
    exp_q.push_back(mk(30, 40, 50, 100, 2'b00, 1'b0));
    @(negedge scaled_clock); continuous = 1'b1;
    for (int s = 0; s < 2; s++) begin
      wait_obs(20000, ok);
      total++;
      if (!ok) begin
        bad++; $display("FAIL cont_scan_%0d: no result_valid within 20000 cycles", s);
      end else begin
        got = obs_q.pop_front(); want = exp_q.pop_front();
        if (got !== want) begin
          bad++; $display("FAIL cont_scan_%0d: got %s required %s", s, fmt(got), fmt(want));
        end
      end
    end
    seq_got = 'x;
    if (seq_q.size() >= 8)
      for (int i = 0; i < 8; i++) seq_got[15 - 2*i -: 2] = seq_q[i];
    total++;
    if (seq_got !== 16'b00_11_01_10_00_11_01_10) begin
      bad++; $display("FAIL cont_seq: got %b required 0011011000110110", seq_got);
    end
    n = 0;
    while ({cs_S2, cs_S3} !== 2'b11 && n < 5000) begin
      @(negedge scaled_clock); n++;
    end
    repeat (10) @(negedge scaled_clock);
    n0 = rv_cnt;
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (out_vec() !== RST_VEC) begin
      bad++; $display("FAIL async_reset: got %h required %h", out_vec(), RST_VEC);
    end
    continuous = 1'b0;
    repeat (3) @(negedge scaled_clock);
    reset_n = 1'b1;
    repeat (200) @(negedge scaled_clock);
    total++;
    if (rv_cnt !== n0 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_abort: pulses=%0d busy=%b required %0d/0", rv_cnt, busy, n0);
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_timeout;
    bit ok;
    res_t got, want;
    exp_q.delete(); obs_q.delete();
    set_periods(40, 50, 0, 100);
    exp_q.push_back(mk(40, 50, 16'hFFFF, 100, 2'b00, 1'b1));
    pulse_start;
    wait_obs(80000, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL timeout_scan: no result_valid within 80000 cycles");
    end else begin
      got = obs_q.pop_front(); want = exp_q.pop_front();
      if (got !== want) begin
        bad++; $display("FAIL timeout_scan: got %s required %s", fmt(got), fmt(want));
      end
    end
    wait_idle(100);
    total++;
    if (timeout_err !== 1'b1) begin
      bad++; $display("FAIL timeout_sticky: got %b required 1", timeout_err);
    end
    set_periods(40, 50, 60, 100);
    exp_q.push_back(mk(40, 50, 60, 100, 2'b00, 1'b0));
    pulse_start;
    repeat (3) @(negedge scaled_clock);
    total++;
    if (timeout_err !== 1'b0) begin
      bad++; $display("FAIL timeout_clear: got %b required 0", timeout_err);
    end
    wait_obs(20000, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL recover_scan: no result_valid within 20000 cycles");
    end else begin
      got = obs_q.pop_front(); want = exp_q.pop_front();
      if (got !== want) begin
        bad++; $display("FAIL recover_scan: got %s required %s", fmt(got), fmt(want));
      end
    end
    wait_idle(100);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_decisions;
    test_average;
    test_start_ignored;
    test_continuous;
    test_timeout;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
